// File: rtl/ipg_tx_sched.sv
// TX inter-packet-gap side-channel scheduler: inserts 9-byte requester messages into the
// free IPG byte slots of 64b/66b control blocks, round-robin, one message at a time.
module ipg_tx_sched #(
  parameter int          NUM_REQ = 4,
  parameter logic [3:0]  HDR_TAG = 4'hA
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ipg_en,
  input  logic [1:0]              in_hdr,
  input  logic [63:0]             in_data,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [64*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [1:0]              out_hdr,
  output logic [63:0]             out_data,
  output logic [5:0]              out_len,
  output logic [1:0]              out_owner
);

  localparam int unsigned NR = NUM_REQ;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state, state_nxt;
  logic [3:0]           byte_idx, byte_idx_nxt;
  logic [1:0]           grant, grant_nxt;
  logic [1:0]           last_grant, last_grant_nxt;

  logic [3:0]           cap;
  logic [3:0]           lo;
  logic                 found;
  logic [1:0]           pick;
  logic                 ins;
  logic [1:0]           cur_grant;
  logic [3:0]           cur_idx;
  logic [71:0]          msg;
  logic [63:0]          data_nxt;
  logic [5:0]           len_nxt;
  logic [1:0]           owner_nxt;
  logic [NUM_REQ-1:0]   ready_nxt;

  // Free IPG slot run of a control block: lowest slot byte and number of bytes.
  always_comb begin
    cap = '0;
    lo  = '0;
    if (in_hdr == 2'b01) begin
      case (in_data[7:0])
        8'h1e: begin lo = 4'd1; cap = 4'd7; end
        8'h2d: begin lo = 4'd1; cap = 4'd3; end
        8'h33: begin lo = 4'd1; cap = 4'd3; end
        8'h4b: begin lo = 4'd5; cap = 4'd3; end
        8'h87: begin lo = 4'd2; cap = 4'd6; end
        8'h99: begin lo = 4'd3; cap = 4'd5; end
        8'haa: begin lo = 4'd4; cap = 4'd4; end
        8'hb4: begin lo = 4'd5; cap = 4'd3; end
        8'hcc: begin lo = 4'd6; cap = 4'd2; end
        8'hd2: begin lo = 4'd7; cap = 4'd1; end
        default: begin lo = '0; cap = '0; end
      endcase
    end
  end

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    int unsigned cand;
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int unsigned off = 1; off <= NR; off++) begin
      cand = (32'(last_grant) + off) % NR;
      for (int unsigned i = 0; i < NR; i++) begin
        if (!found && i == cand && req_valid[i]) begin
          found = 1'b1;
          pick  = 2'(i);
        end
      end
    end
  end

  always_comb begin
    int unsigned rem;
    int unsigned n;
    int unsigned k;
    int unsigned gi;
    state_nxt      = state;
    byte_idx_nxt   = byte_idx;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    ready_nxt      = '0;
    data_nxt       = in_data;
    len_nxt        = '0;
    owner_nxt      = '0;
    ins            = 1'b0;
    cur_grant      = grant;
    cur_idx        = byte_idx;
    rem            = 0;
    n              = 0;
    k              = 0;
    gi             = 0;
    msg            = '0;

    if (ipg_en && cap != '0) begin
      case (state)
        IDLE: begin
          if (found) begin
            ins       = 1'b1;
            cur_grant = pick;
            cur_idx   = '0;
            grant_nxt = pick;
            state_nxt = ACTIVE;
          end
        end
        ACTIVE:  ins = 1'b1;
        default: ins = 1'b0;
      endcase
    end

    if (ins) begin
      gi  = 32'(cur_grant);
      msg = {req_data[gi*64 +: 64], HDR_TAG, 2'b00, cur_grant};
      rem = 9 - 32'(cur_idx);
      n   = (32'(cap) < rem) ? 32'(cap) : rem;
      // Output byte b carries message byte cur_idx + (b - lo) for b inside the slot run.
      for (int unsigned b = 0; b < 8; b++) begin
        if (b >= 32'(lo) && b < 32'(lo) + n) begin
          k = 32'(cur_idx) + b - 32'(lo);
          data_nxt[b*8 +: 8] = msg[k*8 +: 8];
        end
      end
      len_nxt      = 6'(n * 8);
      owner_nxt    = cur_grant;
      byte_idx_nxt = 4'(32'(cur_idx) + n);
      if (32'(cur_idx) + n == 9) begin
        for (int unsigned i = 0; i < NR; i++) begin
          if (i == gi) ready_nxt[i] = 1'b1;
        end
        last_grant_nxt = cur_grant;
        byte_idx_nxt   = '0;
        state_nxt      = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= '0;
      grant      <= '0;
      last_grant <= 2'(NUM_REQ - 1);
      out_hdr    <= 2'b01;
      out_data   <= 64'h1e;
      out_len    <= '0;
      out_owner  <= '0;
      req_ready  <= '0;
    end else begin
      state      <= state_nxt;
      byte_idx   <= byte_idx_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      out_hdr    <= in_hdr;
      out_data   <= data_nxt;
      out_len    <= len_nxt;
      out_owner  <= owner_nxt;
      req_ready  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_ipg_tx_sched.sv
// Bench for ipg_tx_sched: directed scenarios plus randomized traffic, checked against a
// byte-queue reference model of the IPG slot sharing.
module tb_ipg_tx_sched;

  localparam int NUM_REQ = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ipg_en;
  logic [1:0]            in_hdr;
  logic [63:0]           in_data;
  logic [NUM_REQ-1:0]    req_valid;
  logic [64*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [1:0]            out_hdr;
  logic [63:0]           out_data;
  logic [5:0]            out_len;
  logic [1:0]            out_owner;

  ipg_tx_sched #(.NUM_REQ(NUM_REQ), .HDR_TAG(4'hA)) dut (
    .clk(clk), .rst(rst), .ipg_en(ipg_en), .in_hdr(in_hdr), .in_data(in_data),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_hdr(out_hdr), .out_data(out_data), .out_len(out_len), .out_owner(out_owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a granted message is a queue of 9 bytes drained into free slots.
  bit                 m_active;
  logic [1:0]         m_grant;
  int                 m_last;
  logic [7:0]         m_q[$];
  logic [1:0]         e_hdr;
  logic [63:0]        e_data;
  logic [5:0]         e_len;
  logic [1:0]         e_owner;
  logic [NUM_REQ-1:0] e_ready;

  logic [7:0] types[13] = '{8'h1e, 8'h2d, 8'h33, 8'h4b, 8'h87, 8'h99, 8'haa,
                            8'hb4, 8'hcc, 8'hd2, 8'h78, 8'h00, 8'he1};

  function automatic void slot(input logic [1:0] h, input logic [7:0] t,
                               output int lo, output int cap);
    lo = 0; cap = 0;
    if (h == 2'b01) begin
      case (t)
        8'h1e: begin lo = 1; cap = 7; end
        8'h2d, 8'h33: begin lo = 1; cap = 3; end
        8'h4b, 8'hb4: begin lo = 5; cap = 3; end
        8'h87: begin lo = 2; cap = 6; end
        8'h99: begin lo = 3; cap = 5; end
        8'haa: begin lo = 4; cap = 4; end
        8'hcc: begin lo = 6; cap = 2; end
        8'hd2: begin lo = 7; cap = 1; end
        default: begin lo = 0; cap = 0; end
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_q.delete();
    m_last = NUM_REQ - 1;
    m_grant = '0;
  endtask

  task automatic model_step(input logic r, input logic [1:0] h, input logic [63:0] d,
                            input logic en);
    int lo, cap, n, g;
    e_ready = '0;
    e_len   = '0;
    e_owner = '0;
    if (r) begin
      model_reset();
      e_hdr  = 2'b01;
      e_data = 64'h1e;
      return;
    end
    e_hdr  = h;
    e_data = d;
    slot(h, d[7:0], lo, cap);
    if (!(en && cap > 0)) return;
    if (!m_active) begin
      g = -1;
      for (int off = 1; off <= NUM_REQ; off++)
        if (g < 0 && req_valid[(m_last + off) % NUM_REQ]) g = (m_last + off) % NUM_REQ;
      if (g < 0) return;
      m_grant = 2'(g);
      m_active = 1;
      m_q.push_back({4'hA, 2'b00, 2'(g)});
      for (int b = 0; b < 8; b++) m_q.push_back(req_data[g*64 + b*8 +: 8]);
    end
    n = (cap < m_q.size()) ? cap : m_q.size();
    for (int j = 0; j < n; j++) e_data[(lo + j)*8 +: 8] = m_q.pop_front();
    e_len   = 6'(8 * n);
    e_owner = m_grant;
    if (m_q.size() == 0) begin
      e_ready[m_grant] = 1'b1;
      m_last   = int'(m_grant);
      m_active = 0;
    end
  endtask

  task automatic cycle(input logic r, input logic [1:0] h, input logic [63:0] d,
                       input logic en);
    rst = r; in_hdr = h; in_data = d; ipg_en = en;
    model_step(r, h, d, en);
    @(posedge clk);
    #1;
    chk("out_hdr", 64'(out_hdr), 64'(e_hdr));
    chk("out_data", out_data, e_data);
    chk("out_len", 64'(out_len), 64'(e_len));
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    if (e_len != 0) chk("out_owner", 64'(out_owner), 64'(e_owner));
    for (int i = 0; i < NUM_REQ; i++) if (e_ready[i]) req_valid[i] = 1'b0;
  endtask

  task automatic ctrl(input logic [7:0] t);
    cycle(1'b0, 2'b01, {56'h0, t}, 1'b1);
  endtask

  initial begin
    rst = 1'b1; ipg_en = 1'b0; in_hdr = 2'b01; in_data = 64'h1e;
    req_valid = '0; req_data = '0;
    model_reset();

    // Reset state and idle behaviour with no requests.
    cycle(1'b1, 2'b10, 64'hdead_beef_0123_4567, 1'b1);
    chk("reset_data", out_data, 64'h1e);
    cycle(1'b1, 2'b01, 64'h1e, 1'b1);
    ctrl(8'h1e);
    ctrl(8'h87);

    // Single requester over two 1e blocks.
    req_data[63:0] = 64'h8877665544332211;
    req_valid = 4'b0001;
    ctrl(8'h1e);
    chk("t2_blk1", out_data, 64'h665544332211A01E);
    ctrl(8'h1e);
    chk("t2_blk2", out_data, 64'h000000000088771E);
    chk("t2_ready", 64'(req_ready), 64'h1);

    // All four requesters, continuous 1e blocks.
    for (int i = 0; i < NUM_REQ; i++) req_data[i*64 +: 64] = {$urandom, $urandom};
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) ctrl(8'h1e);

    // Requester 2 split over small slot runs.
    req_valid = '0;
    req_data[128 +: 64] = 64'hF0E1D2C3B4A59687;
    req_valid = 4'b0100;
    ctrl(8'hd2); ctrl(8'hcc); ctrl(8'haa); ctrl(8'hb4); ctrl(8'h87);

    // Data blocks and ipg_en=0 interleaved mid-message.
    req_data[64 +: 64] = 64'h0123456789ABCDEF;
    req_valid = 4'b0010;
    ctrl(8'h99);
    cycle(1'b0, 2'b10, 64'h1e1e1e1e1e1e1e1e, 1'b1);
    cycle(1'b0, 2'b01, 64'h1e, 1'b0);
    cycle(1'b0, 2'b10, {$urandom, $urandom}, 1'b1);
    ctrl(8'hcc);
    ctrl(8'h2d);

    // Reset after 4 bytes sent, then re-grant from the header byte.
    req_data[192 +: 64] = 64'h1122334455667788;
    req_valid = 4'b1000;
    ctrl(8'hd2); ctrl(8'hcc); ctrl(8'hd2);
    cycle(1'b1, 2'b01, 64'h1e, 1'b1);
    ctrl(8'h1e);
    chk("t6_regrant_hdr", 64'(out_data[15:8]), 64'hA3);
    ctrl(8'h1e);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic [1:0]  h;
      logic [63:0] d;
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_data[i*64 +: 64] = {$urandom, $urandom};
          req_valid[i] = 1'b1;
        end
      if ($urandom_range(9) < 8) begin
        h = 2'b01;
        d = {56'h0, types[$urandom_range(12)]};
      end else begin
        h = 2'b10;
        d = {$urandom, $urandom};
      end
      cycle(($urandom_range(99) == 0), h, d, ($urandom_range(9) < 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
